bitbang_cfg_rx: RTL and testbench
=================================

# bitbang_cfg_rx

Serial configuration receiver for the eFPGA top. It decodes the two-pin bit-bang configuration protocol (`s_clk`, `s_data`) into 32-bit configuration words and presents each word to the downstream configuration frame writer with a one-cycle strobe. It sits between the chip pads (via `io_in`) and the frame-loading logic, in parallel with the UART configuration path, and reports activity for the status outputs.

## Interface

Parameters:

- `SYNC_STAGES`, 2: flip-flop stages on each of `s_clk` and `s_data`; minimum 2.
- `IDLE_TIMEOUT`, 65535: `CLK` cycles without an `s_clk` edge before `active` drops.
- `CNT_W`, 16: width of `word_count`.

Ports:

- `CLK`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `s_clk`, in, 1: asynchronous bit-bang clock pin.
- `s_data`, in, 1: asynchronous bit-bang data pin.
- `word_o`, out, 32: last accepted configuration word.
- `word_strobe`, out, 1: one-cycle pulse; `word_o` is valid in the same cycle.
- `end_strobe`, out, 1: one-cycle pulse on the end-of-configuration control word.
- `active`, out, 1: configuration session in progress.
- `word_count`, out, CNT_W: words accepted since the last reset or end word.

## Operation

- Both pins pass through `SYNC_STAGES` flops. A registered copy of synced `s_clk` gives the rise and fall detects.
- Each bit takes two phases:
  - Rising edge of synced `s_clk`: shift synced `s_data` into `data_sr`, entering at the LSB and moving toward the MSB. The first bit sent ends up at bit 31.
  - Falling edge: shift synced `s_data` into `ctrl_sr` the same way. Then compare the post-shift value:
    - equals `CTRL_DATA` (32'h0000FAB1): `word_o <= data_sr`; pulse `word_strobe`; increment `word_count` (wraps); set `active`; clear `ctrl_sr` to 0.
    - equals `CTRL_END` (32'h0000FAB0): pulse `end_strobe`; clear `active`; clear `word_count` to 0; clear `ctrl_sr`. `word_o` is unchanged and there is no `word_strobe`.
    - otherwise: no action.
- `data_sr` is never cleared by a match. The next word simply overwrites it over 32 rising edges.
- State machine `active_q`:
  - IDLE to ACTIVE on a `CTRL_DATA` match.
  - ACTIVE to IDLE on a `CTRL_END` match, or when the idle counter reaches `IDLE_TIMEOUT`.
  - The idle counter resets on any `s_clk` edge and counts only in ACTIVE.
  - On timeout, `word_count` holds its value.
- Simultaneous events: a rise and a fall cannot occur in the same cycle. A match and a timeout in the same cycle resolve to the match.
- Reset values: `word_o`=0, `word_strobe`=0, `end_strobe`=0, `active`=0, `word_count`=0, all shift registers 0. The synchronizer flops reset to 0; the stored previous `s_clk` is 0.
- Reset mid-word discards partial bits. If `s_clk` is high when reset releases, a rise is detected.

## Timing

- A pin transition sampled at edge n reaches synced output at edge n+SYNC_STAGES-1.
- Edge detect and shift occur at edge n+SYNC_STAGES.
- `word_strobe`, `word_o` and `end_strobe` are registered at edge n+SYNC_STAGES. They are high for exactly one cycle, during cycle n+SYNC_STAGES to n+SYNC_STAGES+1.
- `s_data` must be stable from 1 cycle before to SYNC_STAGES+1 cycles after each `s_clk` transition. Each `s_clk` level must be held at least 2 `CLK` cycles.
- Throughput: one word per 32 bit periods; no backpressure. The downstream stage must accept every strobe.

## Structure

- Package `cfg_pkg` holds:
  - `CTRL_DATA` and `CTRL_END` constants;
  - `CFG_WORD_W` = 32;
  - the typedef `cfg_word_t`.
- Sub-module `sync_edge_det`:
  - parameterised `SYNC_STAGES`;
  - outputs `level`, `rise`, `fall`;
  - instantiated for `s_clk`.
- `s_data` uses the same module, with only `level` connected.
- The core is the two shift registers, the comparator, the counters and the one-bit state flop.

## Test plan

- Reset: hold `reset` for 3 cycles with pins toggling. All outputs are 0 throughout and one cycle after release.
- Single word: send data 32'hDEADBEEF MSB-first with control 32'h0000FAB1.
  - Exactly one `word_strobe`, with `word_o`=32'hDEADBEEF.
  - `word_count`=1 and `active`=1.
- Mismatch: send data 32'h12345678 with control 32'h0000FAB2. No strobe; `word_o`, `word_count` and `active` are unchanged.
- Back-to-back: 4 words 32'h00000001..32'h00000004, each with `CTRL_DATA`. Four strobes with matching `word_o` in order; `word_count`=4.
- End and timeout:
  - After 2 words, send control `CTRL_END`: one `end_strobe`, `active`=0, `word_count`=0, `word_o` keeps the last word.
  - Separately, with `IDLE_TIMEOUT`=100 and no further edges: `active` falls exactly 100 cycles after the last edge is detected.
- Reset mid-word: reset after 17 bits, then send a full 32'hCAFEF00D word. One strobe with `word_o`=32'hCAFEF00D and `word_count`=1.

Source files
------------

// File: rtl/bitbang_cfg_rx_pkg.sv
// Shared definitions for the bit-bang configuration receiver.
//   CFG_WORD_W  : configuration word width
//   cfg_word_t  : configuration word type
//   CTRL_DATA   : control pattern that commits the data shift register as a word
//   CTRL_END    : control pattern that closes a configuration session
//   cfg_state_t : session state (idle / active)
package cfg_pkg;

    localparam int CFG_WORD_W = 32;

    typedef logic [CFG_WORD_W-1:0] cfg_word_t;

    localparam cfg_word_t CTRL_DATA = 32'h0000_FAB1;
    localparam cfg_word_t CTRL_END  = 32'h0000_FAB0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/bitbang_cfg_rx_if.sv
// Bundle between the pads, the configuration receiver and the frame writer.
//   s_clk, s_data : raw bit-bang pins (asynchronous to CLK)
//   word_o        : last accepted configuration word
//   word_strobe   : one-cycle pulse, word_o valid in the same cycle
//   end_strobe    : one-cycle pulse on the end-of-configuration control word
//   active        : configuration session in progress
//   word_count    : words accepted since reset or the last end word
//   state_dbg     : receiver session state, for observation only
//
// Handshake: word_strobe acts as a valid with no ready. The consumer must take
// word_o in every cycle word_strobe is high; there is no backpressure.
// master = receiver, slave = pin driver / word consumer.
interface bitbang_cfg_rx_if #(
    parameter int CNT_W = 16
);
    import cfg_pkg::*;

    logic             s_clk;
    logic             s_data;
    cfg_word_t        word_o;
    logic             word_strobe;
    logic             end_strobe;
    logic             active;
    logic [CNT_W-1:0] word_count;
    cfg_state_t       state_dbg;

    modport master (
        input  s_clk, s_data,
        output word_o, word_strobe, end_strobe, active, word_count, state_dbg
    );

    modport slave (
        output s_clk, s_data,
        input  word_o, word_strobe, end_strobe, active, word_count, state_dbg
    );

endinterface

// File: rtl/bitbang_cfg_rx_sync_edge_det.sv
// Multi-flop synchroniser with edge detection for one asynchronous pin.
//   CLK, reset : system clock, synchronous active-high reset
//   pin        : asynchronous input
//   level      : synchronised pin level
//   rise, fall : single-cycle pulses when level changes 0->1 / 1->0
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/bitbang_cfg_rx.sv
// Bit-bang configuration receiver. Data bits are shifted on s_clk rising
// edges, control bits on falling edges; the control shift register is
// compared after every falling edge to commit a word or end the session.
//   CLK, reset : system clock, synchronous active-high reset
//   cfg        : pins in, word/strobe/status out (see bitbang_cfg_rx_if)
module bitbang_cfg_rx
    import cfg_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int IDLE_TIMEOUT = 65535,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             reset,
    bitbang_cfg_rx_if.master cfg
);

    // Counter value after which the next idle cycle is the timeout cycle.
    localparam logic [31:0] TIMEOUT_LAST = 32'(IDLE_TIMEOUT - 1);

    logic clk_rise, clk_fall, clk_level_unused;
    logic data_level, data_rise_unused, data_fall_unused;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
        .CLK   (CLK),
        .reset (reset),
        .pin   (cfg.s_clk),
        .level (clk_level_unused),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sdata (
        .CLK   (CLK),
        .reset (reset),
        .pin   (cfg.s_data),
        .level (data_level),
        .rise  (data_rise_unused),
        .fall  (data_fall_unused)
    );

    cfg_word_t        data_sr;
    cfg_word_t        ctrl_sr;
    cfg_word_t        ctrl_next;
    cfg_word_t        word_q;
    logic             word_strobe_q;
    logic             end_strobe_q;
    logic [CNT_W-1:0] count_q;
    logic [31:0]      idle_cnt;
    cfg_state_t       state_q;
    logic             match_data;
    logic             match_end;
    logic             timeout;

    // The comparison is made on the value the control register will hold
    // after this falling edge, so a match acts in the same cycle as the shift.
    always_comb begin
        ctrl_next  = {ctrl_sr[CFG_WORD_W-2:0], data_level};
        match_data = clk_fall && (ctrl_next == CTRL_DATA);
        match_end  = clk_fall && (ctrl_next == CTRL_END);
        timeout    = (state_q == ST_ACTIVE) && !clk_rise && !clk_fall &&
                     (idle_cnt == TIMEOUT_LAST);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            data_sr       <= '0;
            ctrl_sr       <= '0;
            word_q        <= '0;
            word_strobe_q <= 1'b0;
            end_strobe_q  <= 1'b0;
            count_q       <= '0;
            idle_cnt      <= '0;
            state_q       <= ST_IDLE;
        end else begin
            word_strobe_q <= 1'b0;
            end_strobe_q  <= 1'b0;

            if (clk_rise) data_sr <= {data_sr[CFG_WORD_W-2:0], data_level};
            if (clk_fall) ctrl_sr <= ctrl_next;

            if (clk_rise || clk_fall || state_q == ST_IDLE) idle_cnt <= '0;
            else                                            idle_cnt <= idle_cnt + 32'd1;

            // A match takes priority over a timeout in the same cycle.
            if (match_data) begin
                word_q        <= data_sr;
                word_strobe_q <= 1'b1;
                count_q       <= count_q + CNT_W'(1);
                ctrl_sr       <= '0;
                state_q       <= ST_ACTIVE;
            end else if (match_end) begin
                end_strobe_q  <= 1'b1;
                count_q       <= '0;
                ctrl_sr       <= '0;
                state_q       <= ST_IDLE;
            end else if (timeout) begin
                state_q       <= ST_IDLE;
            end
        end
    end

    assign cfg.word_o      = word_q;
    assign cfg.word_strobe = word_strobe_q;
    assign cfg.end_strobe  = end_strobe_q;
    assign cfg.active      = (state_q == ST_ACTIVE);
    assign cfg.word_count  = count_q;
    assign cfg.state_dbg   = state_q;

endmodule

// File: tb/tb_bitbang_cfg_rx.sv
module tb_bitbang_cfg_rx;
    import cfg_pkg::*;

    localparam int SYNC_STAGES  = 2;
    localparam int IDLE_TIMEOUT = 100;
    localparam int CNT_W        = 16;

    logic CLK;
    logic reset;

    bitbang_cfg_rx_if #(.CNT_W(CNT_W)) cfg_if ();

    bitbang_cfg_rx #(
        .SYNC_STAGES  (SYNC_STAGES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .cfg   (cfg_if)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_end = 0;
    int          cyc = 0;
    int          strobe_cyc = 0;
    int          fall_cyc = -1;
    logic        act_prev = 1'b0;

    // Reference model: the last 32 data bits and control bits seen, as bit lists.
    logic        m_dbits[$];
    logic        m_cbits[$];
    logic [31:0] m_word;
    logic [15:0] m_count;
    logic        m_active;
    int          m_end;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: collect strobes and note when active falls.
    always @(negedge CLK) begin
        cyc++;
        if (!reset) begin
            if (cfg_if.word_strobe) begin
                got_q.push_back(cfg_if.word_o);
                strobe_cyc = cyc;
            end
            if (cfg_if.end_strobe) got_end++;
            if (act_prev && !cfg_if.active) fall_cyc = cyc;
        end
        act_prev = cfg_if.active;
    end

    function automatic logic [31:0] bits_to_word(input int use_ctrl);
        logic [31:0] v;
        v = 32'd0;
        if (use_ctrl != 0) begin
            foreach (m_cbits[i]) v = v * 32'd2 + (m_cbits[i] ? 32'd1 : 32'd0);
        end else begin
            foreach (m_dbits[i]) v = v * 32'd2 + (m_dbits[i] ? 32'd1 : 32'd0);
        end
        return v;
    endfunction

    task automatic model_clear();
        m_dbits.delete();
        m_cbits.delete();
        m_word   = 32'd0;
        m_count  = 16'd0;
        m_active = 1'b0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic model_rise(input logic d);
        m_dbits.push_back(d);
        if (m_dbits.size() > 32) void'(m_dbits.pop_front());
    endtask

    task automatic model_fall(input logic c);
        logic [31:0] cval;
        m_cbits.push_back(c);
        if (m_cbits.size() > 32) void'(m_cbits.pop_front());
        cval = bits_to_word(1);
        if (cval == CTRL_DATA) begin
            m_word = bits_to_word(0);
            exp_q.push_back(m_word);
            m_count  = m_count + 16'd1;
            m_active = 1'b1;
            m_cbits.delete();
        end else if (cval == CTRL_END) begin
            m_end++;
            m_count  = 16'd0;
            m_active = 1'b0;
            m_cbits.delete();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic d, input logic c);
        cfg_if.s_data = d;
        repeat (2) @(negedge CLK);
        cfg_if.s_clk = 1'b1;
        model_rise(d);
        repeat (4) @(negedge CLK);
        cfg_if.s_data = c;
        repeat (2) @(negedge CLK);
        cfg_if.s_clk = 1'b0;
        model_fall(c);
        repeat (4) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [31:0] data, input logic [31:0] ctrl);
        for (int i = 31; i >= 0; i--) send_bit(data[i], ctrl[i]);
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge CLK);
        check({tag, "_nstrobe"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({tag, "_end"}, got_end, m_end);
        check({tag, "_word_o"}, cfg_if.word_o, m_word);
        check({tag, "_count"}, cfg_if.word_count, m_count);
        check({tag, "_active"}, cfg_if.active, m_active);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge CLK);
        reset = 1'b0;
        model_clear();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] data;
        logic [31:0] ctrl;
        int          n_strobe;
        int          n_end;
        logic [31:0] word;
        logic [15:0] count;
        logic        act;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          n_before;
        int          end_before;
        logic [31:0] d;
        logic [31:0] c;

        vecs[0]  = '{32'hDEADBEEF, 32'h0000FAB1, 1, 0, 32'hDEADBEEF, 16'd1, 1'b1};
        vecs[1]  = '{32'h12345678, 32'h0000FAB2, 0, 0, 32'hDEADBEEF, 16'd1, 1'b1};
        vecs[2]  = '{32'hAAAA5555, 32'h0000FAB0, 0, 1, 32'hDEADBEEF, 16'd0, 1'b0};
        vecs[3]  = '{32'h00000001, 32'h0000FAB1, 1, 0, 32'h00000001, 16'd1, 1'b1};
        vecs[4]  = '{32'h00000002, 32'h0000FAB1, 1, 0, 32'h00000002, 16'd2, 1'b1};
        vecs[5]  = '{32'h00000003, 32'h0000FAB1, 1, 0, 32'h00000003, 16'd3, 1'b1};
        vecs[6]  = '{32'h00000004, 32'h0000FAB1, 1, 0, 32'h00000004, 16'd4, 1'b1};
        vecs[7]  = '{32'hFFFF0000, 32'h0000FAB0, 0, 1, 32'h00000004, 16'd0, 1'b0};
        vecs[8]  = '{32'h11111111, 32'h0000FAB1, 1, 0, 32'h11111111, 16'd1, 1'b1};
        vecs[9]  = '{32'h22222222, 32'h0000FAB1, 1, 0, 32'h22222222, 16'd2, 1'b1};
        vecs[10] = '{32'h33333333, 32'h0000FAB0, 0, 1, 32'h22222222, 16'd0, 1'b0};

        m_end = 0;
        model_clear();

        // Reset held 3 cycles with pins toggling; outputs must stay zero.
        reset = 1'b1;
        cfg_if.s_clk  = 1'b0;
        cfg_if.s_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            cfg_if.s_clk  = ~cfg_if.s_clk;
            cfg_if.s_data = (i == 1);
            check("reset_outputs",
                  {cfg_if.word_o, cfg_if.word_strobe, cfg_if.end_strobe, cfg_if.active, cfg_if.word_count},
                  64'd0);
        end
        cfg_if.s_clk  = 1'b0;
        cfg_if.s_data = 1'b0;
        reset = 1'b0;
        @(negedge CLK);
        check("post_reset_outputs",
              {cfg_if.word_o, cfg_if.word_strobe, cfg_if.end_strobe, cfg_if.active, cfg_if.word_count},
              64'd0);
        repeat (3) @(negedge CLK);

        // Directed table.
        for (int v = 0; v < 11; v++) begin
            n_before   = got_q.size();
            end_before = got_end;
            send_frame(vecs[v].data, vecs[v].ctrl);
            repeat (6) @(negedge CLK);
            check($sformatf("vec%0d_nstrobe", v), got_q.size() - n_before, vecs[v].n_strobe);
            check($sformatf("vec%0d_nend", v), got_end - end_before, vecs[v].n_end);
            check($sformatf("vec%0d_word_o", v), cfg_if.word_o, vecs[v].word);
            check($sformatf("vec%0d_count", v), cfg_if.word_count, vecs[v].count);
            check($sformatf("vec%0d_active", v), cfg_if.active, vecs[v].act);
            drain($sformatf("vec%0d_model", v));
        end

        // Randomised frames against the model.
        for (int r = 0; r < 20; r++) begin
            int sel;
            d   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 6)       c = CTRL_DATA;
            else if (sel < 8)  c = $urandom;
            else if (sel == 8) c = CTRL_END;
            else               c = CTRL_END ^ (32'h1 << $urandom_range(1, 31));
            send_frame(d, c);
            drain($sformatf("rand%0d", r));
        end

        // Idle timeout: active must drop exactly IDLE_TIMEOUT cycles after the last edge.
        fall_cyc = -1;
        send_frame(32'h0BADF00D, CTRL_DATA);
        repeat (150) @(negedge CLK);
        check("timeout_cycles", fall_cyc - strobe_cyc, IDLE_TIMEOUT);
        m_active = 1'b0;
        drain("timeout");

        // Reset after 17 bits of a word, then a full word.
        d = 32'h5A5A5A5A;
        c = CTRL_DATA;
        for (int i = 31; i >= 15; i--) send_bit(d[i], c[i]);
        do_reset(2);
        @(negedge CLK);
        check("midword_reset_outputs",
              {cfg_if.word_o, cfg_if.active, cfg_if.word_count}, 64'd0);
        n_before = got_q.size();
        send_frame(32'hCAFEF00D, CTRL_DATA);
        repeat (6) @(negedge CLK);
        check("midword_nstrobe", got_q.size() - n_before, 1);
        check("midword_word_o", cfg_if.word_o, 32'hCAFEF00D);
        check("midword_count", cfg_if.word_count, 16'd1);
        drain("midword");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
